apb_slave_if: RTL and testbench
===============================

Name: apb_slave_if

Overview:
- APB (AMBA 3) completer: a small memory-mapped register file that a bus master accesses over APB.
- Sits between the system APB interconnect and local control/status logic; provides a bank of 32-bit read/write registers.
- Supports optional, parameterised wait states via PREADY.
- No error response; the block has no PSLVERR port.

Parameters:
- ADDR_WIDTH, 32, width of paddr.
- DATA_WIDTH, 32, width of pwdata/prdata and of each register.
- NUM_REGS, 16, number of word registers (power of two, >=2).
- WAIT_STATES, 0, access-phase cycles inserted before pready rises (0..15).

Ports:
- pclk  in  1  APB clock; all state updates on the rising edge.
- presetn  in  1  asynchronous, active-low reset.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- prdata  out  DATA_WIDTH  read data.
- penable  in  1  access-phase indicator.
- psel  in  1  completer select.
- pwrite  in  1  1 = write, 0 = read.
- pready  out  1  transfer completes on a rising edge where psel&penable&pready.

Behaviour:
- Interface: one clock (pclk); reset is asynchronous and active-low (presetn).
- Reset (presetn=0, asynchronous): all registers = 0; wait counter = 0; pready = 0; prdata = 0. Held for as long as presetn is low, whatever the bus inputs.
- Phases, derived from the inputs:
  - IDLE: psel=0.
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
- The block keeps only a wait counter, no explicit FSM register.
- Wait counter:
  - Cleared when not in ACCESS or when pready=1.
  - Otherwise increments each cycle.
- pready (combinational): 1 iff ACCESS and wait counter == WAIT_STATES.
  - WAIT_STATES=0: pready rises in the first ACCESS cycle (zero-wait transfer, 2 cycles total).
  - pready = 0 in IDLE and SETUP.
- Address decode:
  - Word index = paddr[log2(NUM_REGS)+1:2]; paddr[1:0] ignored.
  - In range iff paddr < NUM_REGS*4.
- Write: on the rising edge with psel&penable&pwrite&pready and the address in range, reg[index] <= pwdata (full word, no byte strobes).
  - Out-of-range writes are ignored.
  - pwdata is sampled only on the completing edge.
- Read: prdata = reg[index] when psel=1, pwrite=0 and the address is in range; otherwise prdata = 0.
  - Combinational; valid throughout SETUP and ACCESS.
- Back-to-back transfers: SETUP may directly follow a completed ACCESS. Each transfer is independent; a read immediately after a write to the same address returns the new value.
- Master aborts (psel drops mid-ACCESS before pready): no write occurs; the counter clears.
- presetn asserted mid-transfer: the transfer is abandoned, registers clear immediately, pready and prdata go to 0.
- No X propagation: outputs are defined from reset onward.

Decomposition:
- Package apb_slave_if_pkg:
  - ADDR_WIDTH/DATA_WIDTH defaults.
  - NUM_REGS default.
  - Derived IDX_WIDTH = clog2(NUM_REGS).
  - Register-offset constants REG_n_OFFSET = n*4.
- Sub-module apb_slave_if_regfile:
  - NUM_REGS x DATA_WIDTH flops with async clear.
  - One write port (we, widx, wdata) and one combinational read port (ridx, rdata).
- Top level holds the address decode, wait counter and pready/prdata muxing.

Test Plan:
- Reset: presetn=0 for 10 cycles, psel/penable/pwrite=0, paddr=pwdata=0 -> pready=0, prdata=0 throughout; release, then read every address 0x00..0x3C -> all 0.
- Zero-wait write/read (WAIT_STATES=0):
  - Write 0xDEADBEEF to 0x04 -> pready=1 in the first ACCESS cycle.
  - Read 0x04 -> prdata=0xDEADBEEF.
  - Read 0x08 -> 0.
- Wait states (WAIT_STATES=2): write 0x12345678 to 0x3C -> pready low for 2 ACCESS cycles, high on the 3rd; read 0x3C -> 0x12345678.
- Out-of-range/unaligned:
  - Write 0xFFFFFFFF to 0x40 -> no register changes; read 0x40 -> 0.
  - Write 0xA5A5A5A5 to 0x07 -> lands in reg[1]; read 0x04 -> 0xA5A5A5A5.
- Back-to-back: write 0x1 to 0x00, then write 0x2 to 0x00, then read 0x00 with no IDLE between -> 0x2; a SETUP with pwrite=1 and no ACCESS leaves the register unchanged.
- Reset mid-operation: write 0xCAFEF00D to 0x10; start another write and assert presetn during ACCESS -> pready=0 immediately; after release, read 0x10 -> 0.

Source files
------------

// File: rtl/apb_slave_if_pkg.sv
// Shared constants and types for the APB register-file completer.
package apb_slave_if_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 32;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned NUM_REGS_DEF   = 16;
    localparam int unsigned IDX_WIDTH_DEF  = $clog2(NUM_REGS_DEF);

    // Byte offsets of the default register bank.
    localparam int unsigned REG_0_OFFSET  = 0  * 4;
    localparam int unsigned REG_1_OFFSET  = 1  * 4;
    localparam int unsigned REG_2_OFFSET  = 2  * 4;
    localparam int unsigned REG_3_OFFSET  = 3  * 4;
    localparam int unsigned REG_4_OFFSET  = 4  * 4;
    localparam int unsigned REG_5_OFFSET  = 5  * 4;
    localparam int unsigned REG_6_OFFSET  = 6  * 4;
    localparam int unsigned REG_7_OFFSET  = 7  * 4;
    localparam int unsigned REG_8_OFFSET  = 8  * 4;
    localparam int unsigned REG_9_OFFSET  = 9  * 4;
    localparam int unsigned REG_10_OFFSET = 10 * 4;
    localparam int unsigned REG_11_OFFSET = 11 * 4;
    localparam int unsigned REG_12_OFFSET = 12 * 4;
    localparam int unsigned REG_13_OFFSET = 13 * 4;
    localparam int unsigned REG_14_OFFSET = 14 * 4;
    localparam int unsigned REG_15_OFFSET = 15 * 4;

    // Bus phase, decoded combinationally from psel/penable.
    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_ACCESS = 2'd2
    } apb_phase_t;

endpackage

// File: rtl/apb_slave_if_regfile.sv
// Bank of word registers: one synchronous write port, one combinational read port.
module apb_slave_if_regfile
    import apb_slave_if_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned NUM_REGS   = NUM_REGS_DEF,
    parameter int unsigned IDX_WIDTH  = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IDX_WIDTH-1:0]  ridx,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    // Register storage: cleared asynchronously, full-word write when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/apb_slave_if.sv
// APB completer: address decode, wait-state counter and pready/prdata muxing
// in front of a word register file.
module apb_slave_if
    import apb_slave_if_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned NUM_REGS    = NUM_REGS_DEF,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    input  logic                  penable,
    input  logic                  psel,
    input  logic                  pwrite,
    output logic                  pready
);

    localparam int unsigned IDX_WIDTH  = $clog2(NUM_REGS);
    localparam logic [3:0]  WAIT_LIMIT = 4'(WAIT_STATES);

    apb_phase_t            phase;
    logic [3:0]            wait_cnt;
    logic [IDX_WIDTH-1:0]  idx;
    logic                  in_range;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  unused_addr_bits;

    // Decode the bus phase from the select/enable pair.
    always_comb begin
        phase = PH_IDLE;
        if (psel && !penable) begin
            phase = PH_SETUP;
        end else if (psel && penable) begin
            phase = PH_ACCESS;
        end
    end

    assign idx              = paddr[IDX_WIDTH+1:2];
    assign in_range         = (paddr[ADDR_WIDTH-1:IDX_WIDTH+2] == '0);
    assign unused_addr_bits = ^paddr[1:0];

    // pready is gated by presetn so it stays low while reset is held even
    // though the counter sits at zero and would otherwise match WAIT_STATES=0.
    assign pready = presetn && (phase == PH_ACCESS) && (wait_cnt == WAIT_LIMIT);

    // Wait counter: counts ACCESS cycles until the transfer completes or is dropped.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_cnt <= '0;
        end else if (phase != PH_ACCESS || pready) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign wr_en  = pready && pwrite && in_range;
    assign prdata = (presetn && psel && !pwrite && in_range) ? rd_word : '0;

    apb_slave_if_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_regfile (
        .clk   (pclk),
        .rst_n (presetn),
        .we    (wr_en),
        .widx  (idx),
        .wdata (pwdata),
        .ridx  (idx),
        .rdata (rd_word)
    );

endmodule

// File: tb/tb_apb_slave_if.sv
// Scoreboard bench for apb_slave_if: dut0 has no wait states, dut1 has two.
module tb_apb_slave_if;
    import apb_slave_if_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          waits;
    } exp_t;

    logic        pclk;
    logic        presetn;
    logic [1:0]  psel, penable, pwrite, pready;
    logic [31:0] paddr  [2];
    logic [31:0] pwdata [2];
    logic [31:0] prdata [2];

    exp_t q0[$];
    exp_t q1[$];
    int   acc_cnt [2];
    int   checks = 0;
    int   errors = 0;

    apb_slave_if #(.WAIT_STATES(0)) dut0 (
        .pclk(pclk), .presetn(presetn), .paddr(paddr[0]), .pwdata(pwdata[0]),
        .prdata(prdata[0]), .penable(penable[0]), .psel(psel[0]),
        .pwrite(pwrite[0]), .pready(pready[0])
    );

    apb_slave_if #(.WAIT_STATES(2)) dut1 (
        .pclk(pclk), .presetn(presetn), .paddr(paddr[1]), .pwdata(pwdata[1]),
        .prdata(prdata[1]), .penable(penable[1]), .psel(psel[1]),
        .pwrite(pwrite[1]), .pready(pready[1])
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got=%h expected=%h", name, d, $time, got, exp);
        end
    endtask

    // Monitor: on every completing ACCESS pop the expected response and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge pclk);
            for (int d = 0; d < 2; d++) begin
                if (!presetn || !(psel[d] && penable[d])) begin
                    acc_cnt[d] = 0;
                end else if (!pready[d]) begin
                    acc_cnt[d]++;
                end else begin
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        chk("unexpected_completion", d, 32'd1, 32'd0);
                    end else begin
                        e = (d == 0) ? q0.pop_front() : q1.pop_front();
                        chk("wait_cycles", d, 32'(acc_cnt[d]), 32'(e.waits));
                        chk("prdata", d, prdata[d], e.data);
                    end
                    acc_cnt[d] = 0;
                end
            end
        end
    end

    // One transfer; caller is just past a rising edge, and so is the return point.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input bit go_idle);
        exp_t e;
        bit   done;
        e.data  = wr ? 32'd0 : exp_rd;
        e.waits = (d == 0) ? 0 : 2;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
        @(posedge pclk); #1;
        penable[d] = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge pclk);
            done = pready[d];
            @(posedge pclk); #1;
        end
        if (!done) chk("pready_timeout", d, 32'd0, 32'd1);
        penable[d] = 1'b0;
        if (go_idle) psel[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        psel = '0; penable = '0; pwrite = '0;
        repeat (n) begin @(posedge pclk); #1; end
    endtask

    initial begin
        presetn = 1'b0;
        psel = '0; penable = '0; pwrite = '0;
        for (int d = 0; d < 2; d++) begin paddr[d] = '0; pwdata[d] = '0; end

        // Reset held: outputs stay zero, even with bus activity late in the window.
        for (int c = 0; c < 10; c++) begin
            if (c == 5) begin
                psel = '1; penable = '1; pwrite = '0;
                paddr[0] = 32'h4; paddr[1] = 32'h4;
            end
            @(negedge pclk);
            for (int d = 0; d < 2; d++) begin
                chk("reset_pready", d, 32'(pready[d]), 32'd0);
                chk("reset_prdata", d, prdata[d], 32'd0);
            end
        end
        psel = '0; penable = '0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;

        // Every register reads zero after reset.
        for (int i = 0; i < 16; i++) xfer(0, 1'b0, 32'(i * 4), '0, 32'h0, i == 15);
        xfer(1, 1'b0, 32'(REG_15_OFFSET), '0, 32'h0, 1'b1);

        // Zero-wait write/read.
        xfer(0, 1'b1, 32'(REG_1_OFFSET), 32'hDEADBEEF, '0, 1'b1);
        xfer(0, 1'b0, 32'(REG_1_OFFSET), '0, 32'hDEADBEEF, 1'b1);
        xfer(0, 1'b0, 32'(REG_2_OFFSET), '0, 32'h0, 1'b1);

        // Two wait states.
        xfer(1, 1'b1, 32'h3C, 32'h12345678, '0, 1'b1);
        xfer(1, 1'b0, 32'h3C, '0, 32'h12345678, 1'b1);

        // Out of range and unaligned.
        xfer(0, 1'b1, 32'h40, 32'hFFFFFFFF, '0, 1'b1);
        xfer(0, 1'b0, 32'h40, '0, 32'h0, 1'b1);
        xfer(0, 1'b0, 32'h00, '0, 32'h0, 1'b1);
        xfer(0, 1'b0, 32'h3C, '0, 32'h0, 1'b1);
        xfer(0, 1'b1, 32'h07, 32'hA5A5A5A5, '0, 1'b1);
        xfer(0, 1'b0, 32'h04, '0, 32'hA5A5A5A5, 1'b1);

        // Back-to-back without IDLE, then a SETUP that never reaches ACCESS.
        xfer(0, 1'b1, 32'h00, 32'h1, '0, 1'b0);
        xfer(0, 1'b1, 32'h00, 32'h2, '0, 1'b0);
        xfer(0, 1'b0, 32'h00, '0, 32'h2, 1'b1);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h0; pwdata[0] = 32'h99;
        @(posedge pclk); #1;
        idle(1);
        xfer(0, 1'b0, 32'h00, '0, 32'h2, 1'b1);

        // Master abort on the wait-state instance: drop psel before pready.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h3C; pwdata[1] = 32'hBAD0BAD0;
        @(posedge pclk); #1;
        penable[1] = 1'b1;
        @(posedge pclk); #1;
        idle(2);
        xfer(1, 1'b0, 32'h3C, '0, 32'h12345678, 1'b1);

        // Reset asserted during ACCESS.
        xfer(0, 1'b1, 32'(REG_4_OFFSET), 32'hCAFEF00D, '0, 1'b1);
        xfer(0, 1'b0, 32'(REG_4_OFFSET), '0, 32'hCAFEF00D, 1'b1);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h14; pwdata[0] = 32'h11111111;
        @(posedge pclk); #1;
        penable[0] = 1'b1;
        #1;
        chk("access_pready", 0, 32'(pready[0]), 32'd1);
        presetn = 1'b0;
        #1;
        chk("midreset_pready", 0, 32'(pready[0]), 32'd0);
        chk("midreset_prdata", 0, prdata[0], 32'd0);
        @(posedge pclk); #1;
        idle(1);
        presetn = 1'b1;
        @(posedge pclk); #1;
        xfer(0, 1'b0, 32'(REG_4_OFFSET), '0, 32'h0, 1'b1);
        xfer(0, 1'b0, 32'h14, '0, 32'h0, 1'b1);
        xfer(1, 1'b0, 32'h3C, '0, 32'h0, 1'b1);

        idle(3);
        chk("queue0_drained", 0, 32'(q0.size()), 32'd0);
        chk("queue1_drained", 1, 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
